gzip_out_framer: RTL and testbench
==================================

GZIP_OUT_FRAMER -- requirements
Module: gzip_out_framer

Interface
REQ-001 Parameter: COUNT_WIDTH, default 24, width of the frame word counter.
REQ-002 Parameter: BUF_DEPTH, default 4, depth of the internal word buffer (power of 2, at least 2).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset:
- core_clock  in  1  clock for all logic
- bus_reset  in  1  synchronous active-high reset
REQ-004 Ports:
- start  in  1  one-cycle pulse that opens a frame
- rev_endianness  in  1  byte-swap enable, sampled on start
- gzip_done  in  1  level, compressor has written its final word to its output FIFO
- fifo_empty  in  1  compressor output FIFO empty
- fifo_data  in  32  FIFO read data, valid one cycle after fifo_rden
- fifo_rden  out  1  FIFO read strobe
- m_tdata  out  32  AXIS data
- m_tvalid  out  1  AXIS valid
- m_tready  in  1  AXIS ready
- m_tlast  out  1  AXIS last beat of frame
- frame_active  out  1  state is RUN or FLUSH
- frame_done  out  1  state is DONE
- frame_words  out  COUNT_WIDTH  beats accepted in the current or last frame

Function
REQ-005 States SHALL be IDLE, RUN, FLUSH and DONE.
- IDLE -> RUN on start.
- RUN -> FLUSH when the end condition holds: gzip_done_l=1, fifo_empty=1 and pend=0.
- FLUSH -> DONE on the handshake of the tlast beat, or immediately if occ=0.
- DONE -> RUN on start.
- start in RUN or FLUSH SHALL be ignored.
REQ-006 On every entry to RUN the block SHALL:
- clear frame_words, gzip_done_l and the buffer;
- latch rev_endianness into swap_l.
REQ-007 gzip_done_l SHALL be set in RUN whenever gzip_done=1, and cleared only as defined in REQ-006.
REQ-008 fifo_rden SHALL equal (state==RUN) & ~fifo_empty & (occ+pend < BUF_DEPTH), where occ is the buffer occupancy and pend is the registered fifo_rden.
REQ-009 When pend=1, fifo_data SHALL be written into the buffer, byte-reversed ({b0,b1,b2,b3}) if swap_l=1.
REQ-010 m_tdata SHALL be the buffer head.
REQ-011 m_tvalid SHALL be asserted only when one of these holds:
- occ>=2;
- occ=1 and state==FLUSH.
REQ-012 m_tlast SHALL equal m_tvalid & (state==FLUSH) & (occ==1).
REQ-013 When m_tvalid=1, m_tdata, m_tlast and m_tvalid SHALL remain stable until m_tvalid & m_tready.
REQ-014 A buffer write and a head pop in the same cycle SHALL leave occ unchanged with no data loss.
REQ-015 occ SHALL never exceed BUF_DEPTH, and the buffer SHALL never accept a write when full.
REQ-016 frame_words SHALL increment by 1 on each m_tvalid & m_tready, and saturate at 2^COUNT_WIDTH-1.
REQ-017 Throughput SHALL be one beat per cycle while fifo_empty=0 and m_tready=1.
REQ-018 Latency from fifo_rden to the first m_tvalid SHALL be 3 cycles: data arrives and a second word is needed, or the end condition is met.
REQ-019 If the end condition holds with occ=0 (empty frame), the block SHALL reach DONE with no beat emitted and frame_words=0.
REQ-020 gzip_done asserted while words remain in the FIFO SHALL NOT end the frame before the FIFO is empty and every word has been emitted.

Reset
REQ-021 On bus_reset=1 at a core_clock edge:
- state SHALL become IDLE;
- occ, pend, gzip_done_l, swap_l and frame_words SHALL become 0;
- fifo_rden, m_tvalid, m_tlast, frame_active and frame_done SHALL be 0 and m_tdata SHALL be 32'h0 from the following cycle.
REQ-022 bus_reset SHALL take priority over start in the same cycle.
REQ-023 A reset mid-frame SHALL discard buffered words without emitting tlast.

Verification
REQ-024 Basic frame:
- stimulus: start; FIFO holds 5 words 1..5; gzip_done=1; m_tready=1;
- response: 5 beats 1..5, m_tlast only on beat 5, frame_words=5, frame_done=1.
REQ-025 Byte swap:
- stimulus: rev_endianness=1 at start, word 32'h11223344;
- response: m_tdata=32'h44332211.
REQ-026 Backpressure:
- stimulus: 10 words, m_tready toggled 1,0,0,1 repeatedly;
- response: no loss or duplication, data stable while stalled, occ never exceeds 4, fifo_rden=0 while occ+pend=4.
REQ-027 Early done:
- stimulus: gzip_done=1 while 3 words remain in the FIFO;
- response: all 3 words emitted, tlast on the third only.
REQ-028 Empty frame and counter saturation:
- empty frame: end condition with no data gives DONE, frame_words=0, m_tvalid never asserted;
- saturation: COUNT_WIDTH=4 with 20 beats gives frame_words=15.
REQ-029 Mid-frame reset:
- stimulus: bus_reset after 2 of 6 beats;
- response: all outputs 0 the next cycle, IDLE; a new start yields a correct fresh frame.

Source files
------------

// File: rtl/gzip_out_framer.sv
// gzip_out_framer: packs compressor FIFO words into one AXI-Stream frame per start pulse.
// The newest word is held back until end-of-frame is known so tlast lands on the real last word.
module gzip_out_framer #(
    parameter int COUNT_WIDTH = 24,
    parameter int BUF_DEPTH = 4
) (
    input  logic                   core_clock,
    input  logic                   bus_reset,
    input  logic                   start,
    input  logic                   rev_endianness,
    input  logic                   gzip_done,
    input  logic                   fifo_empty,
    input  logic [31:0]            fifo_data,
    output logic                   fifo_rden,
    output logic [31:0]            m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   frame_active,
    output logic                   frame_done,
    output logic [COUNT_WIDTH-1:0] frame_words
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3;
    logic [1:0]    state;
    logic [AW:0]   occ;
    logic [AW-1:0] wp, rp;
    logic [31:0]   mem [BUF_DEPTH];
    logic          pend, gzip_done_l, swap_l, open, end_cond, pop;
    always_comb begin
        open = start & (state == IDLE | state == DONE);
        end_cond = (state == RUN) & gzip_done_l & fifo_empty & ~pend;
        // occ+pend counts words already committed to the buffer, so reads never overfill it
        fifo_rden = (state == RUN) & ~fifo_empty & ((occ + (AW+1)'(pend)) < (AW+1)'(BUF_DEPTH));
        m_tvalid = (occ > (AW+1)'(1)) | ((occ == (AW+1)'(1)) & (state == FLUSH));
        m_tlast = m_tvalid & (state == FLUSH) & (occ == (AW+1)'(1));
        m_tdata = mem[rp];
        pop = m_tvalid & m_tready;
        frame_active = (state == RUN) | (state == FLUSH);
        frame_done = state == DONE;
    end
    always_ff @(posedge core_clock) begin
        if (bus_reset) begin
            state <= IDLE;
            occ <= '0;
            wp <= '0;
            rp <= '0;
            pend <= 1'b0;
            gzip_done_l <= 1'b0;
            swap_l <= 1'b0;
            frame_words <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else if (open) begin
            state <= RUN;
            occ <= '0;
            wp <= '0;
            rp <= '0;
            pend <= 1'b0;
            gzip_done_l <= 1'b0;
            swap_l <= rev_endianness;
            frame_words <= '0;
        end else begin
            pend <= fifo_rden;
            gzip_done_l <= gzip_done_l | (gzip_done & (state == RUN));
            if (end_cond) state <= FLUSH;
            else if ((state == FLUSH) & ((occ == '0) | (m_tlast & m_tready))) state <= DONE;
            if (pend) begin
                mem[wp] <= swap_l ? {fifo_data[7:0], fifo_data[15:8], fifo_data[23:16], fifo_data[31:24]} : fifo_data;
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
                if (frame_words != '1) frame_words <= frame_words + 1'b1;
            end
            occ <= occ + (AW+1)'(pend) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_gzip_out_framer.sv
// tb_gzip_out_framer: directed frames against a queue-based model of the expected AXIS stream.
module tb_gzip_out_framer;
    localparam int CW = 4;
    localparam int DEPTH = 4;
    logic core_clock = 0, bus_reset, start, rev_endianness, gzip_done, fifo_empty, m_tready;
    logic [31:0] fifo_data, m_tdata;
    logic fifo_rden, m_tvalid, m_tlast, frame_active, frame_done;
    logic [CW-1:0] frame_words;

    gzip_out_framer #(.COUNT_WIDTH(CW), .BUF_DEPTH(DEPTH)) dut (
        .core_clock(core_clock), .bus_reset(bus_reset), .start(start),
        .rev_endianness(rev_endianness), .gzip_done(gzip_done), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rden(fifo_rden), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .frame_active(frame_active),
        .frame_done(frame_done), .frame_words(frame_words)
    );

    always #5 core_clock = ~core_clock;

    int checks = 0, failures = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    int total = 0, beats = 0, reads = 0, ncyc = 0, r0 = 0, lat = 0, cyc = 0;
    logic seen_v = 0, chk_en = 0, bp = 0;
    logic [31:0] first_beat = 0, last_data = 0, prev_d = 0;
    logic prev_v = 0, prev_r = 0, prev_l = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] swap32(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
        return r;
    endfunction

    function automatic int sat(input int n);
        return n > (2**CW - 1) ? 2**CW - 1 : n;
    endfunction

    // FIFO emulation: data and empty flag follow a read strobe by one cycle
    initial begin
        logic rd;
        fifo_data = 0;
        forever begin
            @(negedge core_clock);
            rd = fifo_rden;
            @(posedge core_clock);
            #1;
            if (rd && fifo_q.size() > 0) begin
                fifo_data = fifo_q.pop_front();
                fifo_empty = (fifo_q.size() == 0);
            end
        end
    end

    // per-cycle compare against the expected stream
    initial begin
        forever begin
            @(negedge core_clock);
            ncyc++;
            if (chk_en) begin
                if (prev_v && !prev_r) begin
                    chk("stall_valid", m_tvalid, 1);
                    chk("stall_data", m_tdata, prev_d);
                    chk("stall_last", m_tlast, prev_l);
                end
                if (m_tvalid) begin
                    if (exp_q.size() == 0) chk("extra_beat", m_tvalid, 0);
                    else chk("beat_data", m_tdata, exp_q[0]);
                end
                chk("tlast", m_tlast, m_tvalid && (beats + 1 == total));
                chk("frame_words", frame_words, sat(beats));
                chk("occ_bound", (reads - beats) <= DEPTH, 1);
                if (reads - beats == DEPTH) chk("rden_full", fifo_rden, 0);
                if (fifo_rden && reads == 0) r0 = ncyc;
                if (m_tvalid && !seen_v) begin
                    seen_v = 1;
                    lat = ncyc - r0;
                end
                if (fifo_rden) reads++;
                if (m_tvalid && m_tready && exp_q.size() > 0) begin
                    if (beats == 0) first_beat = m_tdata;
                    last_data = m_tdata;
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
            prev_v = m_tvalid;
            prev_r = m_tready;
            prev_d = m_tdata;
            prev_l = m_tlast;
        end
    end

    task automatic tick;
        @(posedge core_clock);
        #1;
        cyc++;
        m_tready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
    endtask

    task automatic clear_model;
        exp_q.delete();
        beats = 0;
        reads = 0;
        seen_v = 0;
        prev_v = 0;
    endtask

    task automatic run_frame(input int n, input logic [31:0] base, input logic [31:0] step,
                             input logic rev, input logic done);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + step * i);
            exp_q.push_back(rev ? swap32(base + step * i) : base + step * i);
        end
        total = n;
        fifo_empty = (n == 0);
        gzip_done = done;
        rev_endianness = rev;
        start = 1;
        tick();
        start = 0;
        rev_endianness = 0;
        beats = 0;
        reads = 0;
        seen_v = 0;
    endtask

    task automatic wait_done;
        int k = 0;
        while (!frame_done && k < 300) begin
            tick();
            k++;
        end
        chk("done_timeout", frame_done, 1);
        chk("drained", exp_q.size(), 0);
        chk("active_at_done", frame_active, 0);
    endtask

    task automatic check_idle;
        @(negedge core_clock);
        chk("rst_rden", fifo_rden, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_active", frame_active, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_tdata", m_tdata, 32'h0);
        chk("rst_words", frame_words, 0);
    endtask

    initial begin
        bus_reset = 1; start = 1; rev_endianness = 0; gzip_done = 0; fifo_empty = 1; m_tready = 1;
        tick();
        bus_reset = 0; start = 0;
        check_idle();
        tick();
        chk("idle_hold", frame_active, 0);
        chk_en = 1;

        run_frame(5, 32'd1, 32'd1, 0, 1);
        wait_done();
        chk("basic_words", frame_words, 5);
        chk("basic_first", first_beat, 32'd1);
        chk("basic_last", last_data, 32'd5);
        chk("basic_latency", lat, 3);

        run_frame(2, 32'h11223344, 32'h44444444, 1, 1);
        wait_done();
        chk("swap_first", first_beat, 32'h44332211);
        chk("swap_words", frame_words, 2);

        bp = 1;
        run_frame(10, 32'h0A0B0C00, 32'h01010101, 0, 1);
        wait_done();
        bp = 0;
        chk("bp_words", frame_words, 10);

        run_frame(3, 32'hCAFE0000, 32'h00000011, 0, 1);
        wait_done();
        chk("early_words", frame_words, 3);
        chk("early_last", last_data, 32'hCAFE0022);

        run_frame(0, 32'h0, 32'h0, 0, 1);
        wait_done();
        chk("empty_words", frame_words, 0);
        chk("empty_seen_valid", seen_v, 0);

        run_frame(20, 32'h100, 32'h1, 0, 1);
        wait_done();
        chk("sat_words", frame_words, 15);

        run_frame(6, 32'h600, 32'h1, 0, 0);
        for (int k = 0; k < 50 && beats < 2; k++) tick();
        chk("pre_reset_beats", beats >= 2, 1);
        bus_reset = 1;
        tick();
        bus_reset = 0;
        #1;
        fifo_q.delete();
        fifo_empty = 1;
        clear_model();
        check_idle();

        run_frame(4, 32'h900, 32'h3, 0, 1);
        wait_done();
        chk("fresh_words", frame_words, 4);
        chk("fresh_first", first_beat, 32'h900);
        chk("fresh_last", last_data, 32'h909);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
